// File: rtl/multi_pwm.sv
// multi_pwm: multi-channel PWM generator with a shared period counter,
// a clock prescaler, and edge- or center-aligned counting.
// Period, mode and duty values are double-buffered: i_load captures them
// into a pending set, which becomes active at the next period boundary.
// Optional feature: define MULTI_PWM_POLARITY_EN to add per-channel output
// polarity (i_pol), buffered together with the duty values.
//
// Counter direction (center-aligned mode only; edge mode always counts up):
//   state    | meaning
//   DIR_UP   | counting 0..P
//   DIR_DOWN | counting P-1..1, then wrapping to 0 at the boundary
module multi_pwm #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 10,
  parameter int PRESCALE_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [PRESCALE_W-1:0]     i_prescale,
  input  logic [WIDTH-1:0]          i_period,
  input  logic                      i_center,
  input  logic [CHANNELS*WIDTH-1:0] i_duty,
  input  logic                      i_load,
`ifdef MULTI_PWM_POLARITY_EN
  input  logic [CHANNELS-1:0]       i_pol,
`endif
  output logic [CHANNELS-1:0]       o_pwm,
  output logic                      o_period_start,
  output logic                      o_pending
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [PRESCALE_W-1:0]     presc_q, presc_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d, cnt_step;
  dir_e                      dir_q, dir_d, dir_step;
  logic [WIDTH-1:0]          per_q, per_d, pend_per_q, pend_per_d;
  logic                      center_q, center_d, pend_center_q, pend_center_d;
  logic [CHANNELS*WIDTH-1:0] duty_q, duty_d, pend_duty_q, pend_duty_d;
  logic                      pending_q, pending_d;
  logic [CHANNELS-1:0]       pwm_q, pwm_d, raw, pol_a;
  logic                      start_q, start_d;
  logic                      tick, boundary, act_from_in, act_from_pend;

  // Prescaler and the counter's next position if a tick occurs now.
  // The >= guard keeps a live lowering of i_prescale from stalling the
  // prescaler for a full wrap of its register.
  always_comb begin
    tick     = (presc_q >= i_prescale);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    cnt_step = cnt_q;
    dir_step = dir_q;
    if (!center_q) begin
      cnt_step = (cnt_q >= per_q) ? '0 : cnt_q + 1'b1;
      dir_step = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= per_q) begin
        cnt_step = (per_q == '0) ? '0 : per_q - 1'b1;
        dir_step = DIR_DOWN;
      end else begin
        cnt_step = cnt_q + 1'b1;
      end
    end else begin
      cnt_step = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    end
    if (cnt_step == '0) dir_step = DIR_UP;
    boundary = tick && (cnt_step == '0);
  end

  // Double-buffer control: a disabled block, or a boundary, lets new
  // values reach the active set; inputs presented that cycle take priority.
  always_comb begin
    act_from_in   = i_load && (!i_en || boundary);
    act_from_pend = pending_q && !i_load && (!i_en || boundary);
    per_d         = per_q;
    center_d      = center_q;
    duty_d        = duty_q;
    pend_per_d    = pend_per_q;
    pend_center_d = pend_center_q;
    pend_duty_d   = pend_duty_q;
    if (i_load) begin
      pend_per_d    = i_period;
      pend_center_d = i_center;
      pend_duty_d   = i_duty;
    end
    if (act_from_in) begin
      per_d    = i_period;
      center_d = i_center;
      duty_d   = i_duty;
    end else if (act_from_pend) begin
      per_d    = pend_per_q;
      center_d = pend_center_q;
      duty_d   = pend_duty_q;
    end
    if (!i_en || boundary) pending_d = 1'b0;
    else if (i_load)       pending_d = 1'b1;
    else                   pending_d = pending_q;
  end

  // Counter advance; disable parks everything at the start of a period.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!i_en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      cnt_d = cnt_step;
      dir_d = dir_step;
    end
  end

  // Per-channel compare against the active duty values.
  always_comb begin
    raw = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      raw[c] = (cnt_q < duty_q[c*WIDTH +: WIDTH]);
    end
  end

  // Output stage, one clock behind the counter. The period-start pulse marks
  // the first clock of count 0, which is also the first prescaler phase.
  always_comb begin
    pwm_d   = i_en ? (raw ^ pol_a) : pol_a;
    start_d = i_en && (cnt_q == '0) && (presc_q == '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q       <= '0;
      cnt_q         <= '0;
      dir_q         <= DIR_UP;
      per_q         <= '0;
      center_q      <= 1'b0;
      duty_q        <= '0;
      pend_per_q    <= '0;
      pend_center_q <= 1'b0;
      pend_duty_q   <= '0;
      pending_q     <= 1'b0;
      pwm_q         <= '0;
      start_q       <= 1'b0;
    end else begin
      presc_q       <= i_en ? presc_d : '0;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      per_q         <= per_d;
      center_q      <= center_d;
      duty_q        <= duty_d;
      pend_per_q    <= pend_per_d;
      pend_center_q <= pend_center_d;
      pend_duty_q   <= pend_duty_d;
      pending_q     <= pending_d;
      pwm_q         <= pwm_d;
      start_q       <= start_d;
    end
  end

`ifdef MULTI_PWM_POLARITY_EN
  logic [CHANNELS-1:0] pol_q, pend_pol_q;

  // Polarity moves through the pending and active sets with the duty values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pol_q      <= '0;
      pend_pol_q <= '0;
    end else begin
      if (i_load) pend_pol_q <= i_pol;
      if (act_from_in)        pol_q <= i_pol;
      else if (act_from_pend) pol_q <= pend_pol_q;
    end
  end

  assign pol_a = pol_q;
`else
  assign pol_a = '0;
`endif

  assign o_pwm          = pwm_q;
  assign o_period_start = start_q;
  assign o_pending      = pending_q;

endmodule

// File: doc/multi_pwm.md
Name: multi_pwm

Overview:
Parametrised multi-channel PWM generator and the next generation of the single-channel switch-driven PWM. It has N channels on one shared period counter, a programmable clock prescaler, and edge-aligned or center-aligned counting. Duty, period and mode are double-buffered and take effect only at period boundaries. It sits between board-level control logic (switches/keys or a register block) and GPIO pins that drive LEDs or motor drivers.

Parameters:
CHANNELS, 4, number of independent PWM outputs sharing one counter
WIDTH, 10, bit width of period counter, period and each duty value
PRESCALE_W, 8, bit width of the prescaler reload value

Ports:
i_clk  input  1  system clock; single clock domain
i_rst  input  1  synchronous reset, active-high
i_en  input  1  run enable; low holds the counter and forces outputs inactive
i_prescale  input  PRESCALE_W  counter advances once every i_prescale+1 clocks
i_period  input  WIDTH  period value P (unsigned)
i_center  input  1  0 = edge-aligned, 1 = center-aligned
i_duty  input  CHANNELS*WIDTH  packed duty values; channel c uses bits [c*WIDTH +: WIDTH]
i_load  input  1  one-clock strobe; captures i_period, i_center, i_duty into the pending set
o_pwm  output  CHANNELS  registered PWM outputs
o_period_start  output  1  one-clock pulse marking the first count of each period
o_pending  output  1  high while a captured pending set awaits its boundary

Behaviour:
- Reset (i_rst high at a rising edge): counter=0, direction=up, prescaler=0, active and pending sets=0, o_pwm=0, o_period_start=0, o_pending=0. Reset overrides every other input in the same cycle, including mid-period.
- Prescaler: counts 0..i_prescale. Tick is asserted when it equals i_prescale, then it wraps to 0. i_prescale=0 gives a tick every clock. i_prescale is not buffered and is sampled live.
- Edge mode: counter runs 0,1..P, then back to 0. A period is P+1 ticks.
- Center mode: counter runs up 0..P, then down P-1..1, then back to 0. A period is 2P ticks. If P=0, the counter stays at 0 and the period is 1 tick.
- Boundary: a tick that moves the counter to 0, or keeps it at 0 when P=0.
- Compare: raw[c] = (cnt < duty[c]), unsigned compare on the active set.
  - duty=0 gives constant 0.
  - duty>P (edge) or duty>=P+1 (center) gives constant 1.
- Outputs: o_pwm and o_period_start are registered from the current counter state, giving 1 clock latency from counter to pin. o_period_start is high for exactly 1 clock while cnt=0, on the first clock of that count.
- Double-buffering:
  - i_load copies the inputs into the pending set and sets o_pending.
  - At the next boundary, pending is copied to active, o_pending clears, and the counter restarts with the new P and mode.
  - If i_load coincides with a boundary tick, the just-presented inputs go straight to active and o_pending stays 0.
  - A second i_load before the boundary overwrites the pending set (last write wins).
- Disable (i_en=0): counter=0, direction=up, prescaler=0, o_pwm=0, o_period_start=0. i_load writes both pending and active sets; o_pending stays 0.
- Enable (i_en rising): the next clock begins a fresh period at cnt=0 and pulses o_period_start.
- Reducing P below the current count never happens mid-period, because P changes only at boundaries. The counter cannot overrun.

Optional Feature:
Macro: MULTI_PWM_POLARITY_EN
- Defined: adds port i_pol (input, CHANNELS bits). i_pol is double-buffered with the duty values. Output is o_pwm[c] = raw[c] XOR pol[c]. While disabled or in reset, o_pwm[c] = pol[c] (inactive level), with pol=0 after reset.
- Not defined: port i_pol is absent and all outputs are active-high with inactive level 0.

Test Plan:
1. Edge-aligned basic: prescale=0, P=9, center=0, duty0=3, load while disabled, then enable. Required: o_pwm[0] is high 3 clocks of every 10; o_period_start pulses every 10 clocks, aligned with the o_pwm rising edge.
2. Prescaler: prescale=4, P=9, duty0=5. Required: o_pwm[0] is high 25 clocks of every 50; o_period_start has a 50-clock spacing.
3. Center-aligned: prescale=0, P=4, center=1, duty1=2. Required: counter sequence 0,1,2,3,4,3,2,1 repeats; o_pwm[1] is high 3 of every 8 clocks (counts 0,1 and the trailing 1); period is 8.
4. Double-buffer: running with P=9, duty0=3; pulse i_load with duty0=7 at cnt=5. Required: o_pending goes high; the current period keeps 3-high; from the next o_period_start duty is 7-high; o_pending clears on that boundary.
5. Extremes: duty=0 on channel 2 and duty=15 with P=9 on channel 3. Required: o_pwm[2] is constant 0 and o_pwm[3] is constant 1 across 3 periods. A simultaneous load and boundary applies immediately, with o_pending never asserted.
6. Reset and disable mid-period: assert i_rst at cnt=6, then separately drop i_en at cnt=4. Required: all outputs are 0 the next clock; after release or re-enable, the first o_period_start appears 1 clock later and the duty pattern restarts from cnt=0.
